// File: rtl/interface_hcsr04_param.sv
// interface_hcsr04_param: HC-SR04 trigger/echo interface with BCD centimetre result.
// Define HCSR04_TIMEOUT_EN to abort a measurement with erro=1 after TIMEOUT clocks without echo fall.
module interface_hcsr04_param #(
    parameter int LARGURA_TRIGGER = 500,
    parameter int R               = 2941,
    parameter int DIGITOS         = 3,
    parameter int TIMEOUT         = 1500000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   medir,
    input  logic                   echo,
    output logic                   trigger,
    output logic [4*DIGITOS-1:0]   medida,
    output logic                   pronto,
    output logic                   fim,
    output logic                   erro,
    output logic [3:0]             db_estado
);
    localparam int TKW = $clog2(R);
    localparam int TGW = $clog2(LARGURA_TRIGGER + 1);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        PREPARA  = 4'd1,
        ENVIA    = 4'd2,
        ESPERA   = 4'd3,
        MEDE     = 4'd4,
        ARMAZENA = 4'd5,
        FINAL    = 4'd6
    } estado_t;

    estado_t estado, proximo;
    logic echo_m, echo_s;
    logic [TKW-1:0] tick;
    logic [TGW-1:0] larg;
    logic [4*DIGITOS-1:0] bcd, bcd_inc;
    logic saturado, carry, timeout, conta;

    // The cycle that detects echo in ESPERA is already the first counted clock.
    assign conta = echo_s && (estado == ESPERA || estado == MEDE);

    always_comb begin
        bcd_inc = bcd;
        carry = 1'b1;
        saturado = 1'b1;
        for (int i = 0; i < DIGITOS; i++) begin
            saturado = saturado & (bcd[4*i +: 4] == 4'd9);
            if (carry) begin
                bcd_inc[4*i +: 4] = (bcd[4*i +: 4] == 4'd9) ? 4'd0 : bcd[4*i +: 4] + 4'd1;
                carry = (bcd[4*i +: 4] == 4'd9);
            end
        end
        if (saturado) bcd_inc = bcd;
    end

    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:  proximo = medir ? PREPARA : INICIAL;
            PREPARA:  proximo = ENVIA;
            ENVIA:    proximo = (larg == TGW'(LARGURA_TRIGGER - 1)) ? ESPERA : ENVIA;
            ESPERA:   proximo = timeout ? FINAL : echo_s ? MEDE : ESPERA;
            MEDE:     proximo = timeout ? FINAL : echo_s ? MEDE : ARMAZENA;
            ARMAZENA: proximo = FINAL;
            default:  proximo = INICIAL;
        endcase
        trigger = (estado == ENVIA);
        pronto = (estado == FINAL);
        db_estado = estado;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            larg <= '0;
            tick <= '0;
            bcd <= '0;
            medida <= '0;
            fim <= 1'b0;
        end else begin
            estado <= proximo;
            echo_m <= echo;
            echo_s <= echo_m;
            larg <= (estado == ENVIA) ? larg + 1'b1 : '0;
            if (estado == PREPARA) begin
                tick <= '0;
                bcd <= '0;
            end else if (conta) begin
                tick <= (tick == TKW'(R - 1)) ? '0 : tick + 1'b1;
                if (tick == TKW'(R - 1)) bcd <= bcd_inc;
            end else if (estado == MEDE && tick >= TKW'(R / 2)) begin
                bcd <= bcd_inc;
            end
            if (estado == ARMAZENA) begin
                medida <= bcd;
                fim <= saturado;
            end else if (timeout) begin
                fim <= 1'b0;
            end
        end
    end

`ifdef HCSR04_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT + 1);
    logic [TOW-1:0] to_cnt;

    assign timeout = (estado == ESPERA || estado == MEDE) && to_cnt == TOW'(TIMEOUT - 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt <= '0;
            erro <= 1'b0;
        end else begin
            to_cnt <= (estado == ESPERA || estado == MEDE) ? to_cnt + 1'b1 : '0;
            if (timeout) erro <= 1'b1;
            else if (estado == ARMAZENA) erro <= 1'b0;
        end
    end
`else
    assign timeout = 1'b0;
    // Never true for a valid TIMEOUT, so erro stays constant 0.
    assign erro = (TIMEOUT < 0);
`endif
endmodule

// File: tb/tb_interface_hcsr04_param.sv
// tb_interface_hcsr04_param: scoreboard bench for interface_hcsr04_param with small R and trigger width.
module tb_interface_hcsr04_param;
    localparam int LT = 12;
    localparam int RR = 7;
    localparam int DG = 3;
    localparam int TO = 12000;

    logic clock = 1'b0;
    logic reset, medir, echo;
    logic trigger, pronto, fim, erro;
    logic [4*DG-1:0] medida;
    logic [3:0] db_estado;

    typedef struct {
        logic [11:0] medida;
        logic        fim;
        logic        erro;
    } esp_t;

    esp_t fila[$];
    logic [11:0] last = '0;
    int checks = 0;
    int errors = 0;

    interface_hcsr04_param #(.LARGURA_TRIGGER(LT), .R(RR), .DIGITOS(DG), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .medir(medir), .echo(echo), .trigger(trigger),
        .medida(medida), .pronto(pronto), .fim(fim), .erro(erro), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    function automatic esp_t modelo(input int w);
        esp_t e;
        int q;
        q = w / RR + (((w % RR) >= RR / 2) ? 1 : 0);
        if (q > 999) q = 999;
        e.medida = {4'(q / 100), 4'((q / 10) % 10), 4'(q % 10)};
        e.fim = (q == 999);
        e.erro = 1'b0;
        return e;
    endfunction

    task automatic dispara();
        int n;
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
        n = 0;
        while (db_estado !== 4'd3 && n < LT + 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (db_estado !== 4'd3) begin
            errors++;
            $display("FAIL reach_espera: db_estado %0d, want 3", db_estado);
        end
    endtask

    // Assumes ESPERA; drives echo for w clocks, optionally pulsing medir at index medir_em.
    task automatic pulso(input int w, input int medir_em);
        esp_t e;
        int lat;
        fila.push_back(modelo(w));
        repeat (3) @(negedge clock);
        echo = 1'b1;
        for (int i = 0; i < w; i++) begin
            medir = (i == medir_em);
            @(negedge clock);
        end
        medir = 1'b0;
        echo = 1'b0;
        lat = 0;
        while (pronto !== 1'b1 && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        e = fila.pop_front();
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL latency w=%0d: got %0d clk, want 4", w, lat);
        end
        checks++;
        if (medida !== e.medida) begin
            errors++;
            $display("FAIL medida w=%0d: got %h, want %h", w, medida, e.medida);
        end
        checks++;
        if (fim !== e.fim) begin
            errors++;
            $display("FAIL fim w=%0d: got %b, want %b", w, fim, e.fim);
        end
        checks++;
        if (erro !== e.erro) begin
            errors++;
            $display("FAIL erro w=%0d: got %b, want %b", w, erro, e.erro);
        end
        last = e.medida;
        @(negedge clock);
        checks++;
        if (pronto !== 1'b0) begin
            errors++;
            $display("FAIL pronto_width w=%0d: got %b, want 0", w, pronto);
        end
    endtask

    task automatic medicao(input int w);
        dispara();
        pulso(w, -1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        medir = 1'b0;
        echo = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({trigger, pronto, fim, erro, medida, db_estado} !== '0) begin
            errors++;
            $display("FAIL reset: trig %b pronto %b fim %b erro %b medida %h estado %0d, want all 0",
                     trigger, pronto, fim, erro, medida, db_estado);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_trigger();
        int n;
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
        checks++;
        if (db_estado !== 4'd1) begin
            errors++;
            $display("FAIL estado_prepara: got %0d, want 1", db_estado);
        end
        @(negedge clock);
        checks++;
        if (db_estado !== 4'd2 || trigger !== 1'b1) begin
            errors++;
            $display("FAIL estado_envia: got %0d trig %b, want 2 trig 1", db_estado, trigger);
        end
        n = 1;
        while (trigger === 1'b1 && n < LT + 10) begin
            @(negedge clock);
            if (trigger === 1'b1) n++;
        end
        checks++;
        if (n != LT) begin
            errors++;
            $display("FAIL trigger_width: got %0d clk, want %0d", n, LT);
        end
        checks++;
        if (db_estado !== 4'd3) begin
            errors++;
            $display("FAIL estado_espera: got %0d, want 3", db_estado);
        end
        pulso(5 * RR, -1);
    endtask

    task automatic test_rounding();
        medicao(RR + RR / 2);
        medicao(RR + RR / 2 - 1);
        medicao(RR / 2);
        medicao(RR / 2 - 1);
    endtask

    task automatic test_carry();
        medicao(99 * RR);
        medicao(10 * RR - 1);
    endtask

    task automatic test_saturation();
        medicao(1000 * RR);
        medicao(999 * RR - 4);
        medicao(5 * RR);
    endtask

    task automatic test_ignored();
        dispara();
        pulso(20, 5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (db_estado !== 4'd0) begin
                errors++;
                $display("FAIL medir_ignored: estado %0d, want 0", db_estado);
            end
        end
    endtask

`ifdef HCSR04_TIMEOUT_EN
    task automatic test_timeout();
        esp_t e;
        int n;
        e.medida = last;
        e.fim = 1'b0;
        e.erro = 1'b1;
        fila.push_back(e);
        dispara();
        n = 0;
        while (pronto !== 1'b1 && n < TO + 50) begin
            @(negedge clock);
            n++;
        end
        e = fila.pop_front();
        checks++;
        if (n != TO) begin
            errors++;
            $display("FAIL timeout_delay: got %0d clk, want %0d", n, TO);
        end
        checks++;
        if (erro !== e.erro || fim !== e.fim || medida !== e.medida) begin
            errors++;
            $display("FAIL timeout_flags: erro %b fim %b medida %h, want %b %b %h",
                     erro, fim, medida, e.erro, e.fim, e.medida);
        end
        @(negedge clock);
        medicao(3 * RR);
    endtask
`endif

    task automatic test_reset_mid();
        dispara();
        echo = 1'b1;
        repeat (30) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (db_estado !== 4'd0 || medida !== '0 || trigger !== 1'b0 || fim !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: estado %0d medida %h trig %b fim %b, want 0 0 0 0",
                     db_estado, medida, trigger, fim);
        end
        reset = 1'b0;
        echo = 1'b0;
        repeat (5) @(negedge clock);
        medicao(2 * RR);
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_rounding();
        test_carry();
        test_saturation();
        test_ignored();
`ifdef HCSR04_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
